// File: rtl/mem_sram_responder.sv
// mem_sram_responder: memory-bus responder driving a single-port byte-maskable SRAM with programmable wait states
module mem_sram_responder #(
  parameter int          MEM_WORDS   = 512,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  localparam int         AW          = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_wmask,
  input  logic          mem_wstrb,
  input  logic          mem_rstrb,
  output logic [31:0]   mem_rdata,
  output logic          mem_done,
  output logic          mem_err,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [3:0]    sram_wmask,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);
  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, CAPTURE, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic hit_q, hit_d, wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wmask_q, wmask_d;
  logic [32:0] lo_x, hi_x, a_x;
  logic [31:0] off;
  logic hit;
  logic unused_off;
  assign a_x = {1'b0, mem_addr};
  assign lo_x = {1'b0, BASE_ADDR};
  assign hi_x = lo_x + 33'(4 * MEM_WORDS);
  assign hit = (a_x >= lo_x) && (a_x < hi_x);
  assign off = mem_addr - BASE_ADDR;
  assign unused_off = ^{off[31:AW+2], off[1:0]};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    hit_d = hit_q;
    wr_d = wr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (mem_wstrb || mem_rstrb) begin
        idx_d = off[AW+1:2];
        hit_d = hit;
        wr_d = mem_wstrb;
        wdata_d = mem_wdata;
        wmask_d = mem_wmask;
        cnt_d = 4'(WAIT_STATES);
        state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? ACCESS : WAIT;
      end
      ACCESS: state_d = wr_q ? DONE : CAPTURE;
      CAPTURE: begin
        rdata_d = hit_q ? sram_rdata : 32'h0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      hit_q <= 1'b0;
      wr_q <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      hit_q <= hit_d;
      wr_q <= wr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end
  assign mem_rdata = rdata_q;
  assign mem_done = state_q == DONE;
  assign mem_err = (state_q == DONE) && !hit_q;
  assign sram_cs = (state_q == ACCESS) && hit_q;
  assign sram_we = (state_q == ACCESS) && hit_q && wr_q;
  assign sram_wmask = ((state_q == ACCESS) && wr_q) ? wmask_q : 4'h0;
  assign sram_addr = idx_q;
  assign sram_wdata = wdata_q;
endmodule

// File: tb/tb_mem_sram_responder.sv
// tb_mem_sram_responder: directed plus random checks of two responders (0 and 3 wait states) against a word-array model
module tb_mem_sram_responder;
  localparam int WORDS = 512;
  localparam logic [31:0] BASE = 32'h0;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0] mem_wmask = '0;
  logic mem_wstrb = 1'b0, mem_rstrb = 1'b0;
  logic [31:0] rdata0, rdata3, wd0, wd3, srd0, srd3;
  logic done0, done3, err0, err3, cs0, cs3, we0, we3;
  logic [3:0] wm0, wm3;
  logic [8:0] sa0, sa3;
  logic [31:0] m0 [WORDS] = '{default: 32'h0};
  logic [31:0] m3 [WORDS] = '{default: 32'h0};
  logic [31:0] ref_mem [WORDS] = '{default: 32'h0};
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  mem_sram_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wstrb(mem_wstrb), .mem_rstrb(mem_rstrb), .mem_rdata(rdata0), .mem_done(done0), .mem_err(err0),
    .sram_cs(cs0), .sram_we(we0), .sram_wmask(wm0), .sram_addr(sa0), .sram_wdata(wd0), .sram_rdata(srd0));
  mem_sram_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wstrb(mem_wstrb), .mem_rstrb(mem_rstrb), .mem_rdata(rdata3), .mem_done(done3), .mem_err(err3),
    .sram_cs(cs3), .sram_we(we3), .sram_wmask(wm3), .sram_addr(sa3), .sram_wdata(wd3), .sram_rdata(srd3));
  always @(posedge clk) begin
    if (cs0) begin
      if (we0) begin
        for (int b = 0; b < 4; b++) if (wm0[b]) m0[sa0][8*b +: 8] <= wd0[8*b +: 8];
      end else srd0 <= m0[sa0];
    end
    if (cs3) begin
      if (we3) begin
        for (int b = 0; b < 4; b++) if (wm3[b]) m3[sa3][8*b +: 8] <= wd3[8*b +: 8];
      end else srd3 <= m3[sa3];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bit hit;
    logic [8:0] ix;
    logic [31:0] er;
    int l0, l3, c0, c3, t0, t3, n0;
    hit = (33'(a) >= 33'(BASE)) && (33'(a) < 33'(BASE) + 33'(4 * WORDS));
    ix = 9'((a - BASE) >> 2);
    er = hit ? ref_mem[ix] : 32'h0;
    if (wr && hit) for (int b = 0; b < 4; b++) if (m[b]) ref_mem[ix][8*b +: 8] = d[8*b +: 8];
    @(negedge clk);
    mem_addr = a; mem_wdata = d; mem_wmask = m; mem_wstrb = wr; mem_rstrb = rd;
    l0 = -1; l3 = -1; c0 = 0; c3 = 0; t0 = -1; t3 = -1; n0 = 0;
    for (int k = 1; k <= 30 && l3 < 0; k++) begin
      @(negedge clk);
      if (cs0) begin
        c0++; t0 = k;
        chk("we0", 32'(we0), 32'(wr));
        chk("wmask0", 32'(wm0), wr ? 32'(m) : 32'h0);
        chk("addr0", 32'(sa0), 32'(ix));
        if (wr) chk("wdata0", wd0, d);
      end
      if (cs3) begin
        c3++; t3 = k;
        chk("we3", 32'(we3), 32'(wr));
        chk("addr3", 32'(sa3), 32'(ix));
      end
      if (done0) begin
        n0++;
        if (l0 < 0) begin
          l0 = k;
          chk("err0", 32'(err0), 32'(!hit));
          if (!wr) chk("rdata0", rdata0, er);
          mem_wstrb = 1'b0; mem_rstrb = 1'b0;
        end
      end
      if (done3) begin
        l3 = k;
        chk("err3", 32'(err3), 32'(!hit));
        if (!wr) chk("rdata3", rdata3, er);
      end
    end
    mem_wstrb = 1'b0; mem_rstrb = 1'b0;
    chk("lat0", 32'(l0), wr ? 32'd2 : 32'd3);
    chk("lat3", 32'(l3), wr ? 32'd5 : 32'd6);
    chk("cs_count0", 32'(c0), 32'(hit));
    chk("cs_count3", 32'(c3), 32'(hit));
    chk("done_count0", 32'(n0), 32'd1);
    if (hit) begin
      chk("cs_cycle0", 32'(t0), 32'd1);
      chk("cs_cycle3", 32'(t3), 32'd4);
    end
  endtask
  initial begin
    int nd;
    bit wr, rd;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", 32'({done0, done3}), 32'h0);
    chk("rst_err", 32'({err0, err3}), 32'h0);
    chk("rst_rdata", rdata0 | rdata3, 32'h0);
    chk("rst_cs_we", 32'({cs0, we0, cs3, we3}), 32'h0);
    chk("rst_wmask_addr", 32'({wm0, sa0}), 32'h0);
    chk("rst_wdata", wd0, 32'h0);
    reset = 1'b0;
    txn(1, 0, 32'h10, 32'hCAFEF00D, 4'hF);
    txn(0, 1, 32'h10, 32'h0, 4'h0);
    chk("wr_rd_data", rdata0, 32'hCAFEF00D);
    txn(1, 0, 32'h20, 32'h11223344, 4'hF);
    txn(1, 0, 32'h20, 32'hAABBCCDD, 4'b0101);
    txn(0, 1, 32'h20, 32'h0, 4'h0);
    chk("bytemask", rdata0, 32'h11BB33DD);
    txn(1, 0, 32'h20, 32'h55555555, 4'h0);
    txn(0, 1, 32'h23, 32'h0, 4'h0);
    chk("wmask_zero", rdata0, 32'h11BB33DD);
    txn(1, 0, 32'h800, 32'hDEADBEEF, 4'hF);
    txn(0, 1, 32'h800, 32'h0, 4'h0);
    chk("miss_rdata", rdata0, 32'h0);
    txn(1, 0, 32'hFFFF_FFFC, 32'h12345678, 4'hF);
    txn(0, 1, 32'h0000_07FC, 32'h0, 4'h0);
    txn(1, 1, 32'h40, 32'h600DF00D, 4'hF);
    txn(0, 1, 32'h40, 32'h0, 4'h0);
    chk("both_strobes", rdata0, 32'h600DF00D);
    @(negedge clk);
    mem_addr = 32'h10; mem_rstrb = 1'b1; nd = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (done0) nd++;
      if (k == 3 || k == 7) chk("b2b_done", 32'(done0), 32'h1);
      if (k == 7) chk("b2b_rdata", rdata0, ref_mem[4]);
    end
    mem_rstrb = 1'b0;
    chk("b2b_count", 32'(nd), 32'd2);
    repeat (12) @(negedge clk);
    mem_addr = 32'h10; mem_rstrb = 1'b1;
    @(negedge clk);
    chk("rst_acc_cs", 32'(cs0), 32'h1);
    reset = 1'b1; mem_rstrb = 1'b0;
    @(negedge clk);
    chk("rst_acc_out", 32'({done0, err0, cs0, we0, wm0, done3, cs3}), 32'h0);
    chk("rst_acc_addr", 32'(sa0), 32'h0);
    chk("rst_acc_rdata", rdata0, 32'h0);
    reset = 1'b0; nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0 || done3) nd++;
    end
    chk("rst_acc_nodone", 32'(nd), 32'h0);
    txn(0, 1, 32'h10, 32'h0, 4'h0);
    chk("rst_acc_after", rdata0, 32'hCAFEF00D);
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = !wr || ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h800) : ($urandom & 32'h7FF);
      if ($urandom_range(0, 1) == 1) a = {23'h0, a[8:7], 7'h0} | (a & 32'hFFFF_F803);
      txn(wr, rd, a, $urandom, 4'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
